// File: rtl/mem_access_stage_if.sv
// Data-memory port of the MEM stage: request/ack handshake with byte enables.
interface mem_access_stage_if;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic [3:0]  memBe;
  logic [31:0] memRdata;
  logic        memAck;

  modport master (
    output memReq, memWe, memAddr, memWdata, memBe,
    input  memRdata, memAck
  );

  modport slave (
    input  memReq, memWe, memAddr, memWdata, memBe,
    output memRdata, memAck
  );
endinterface

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: branch resolution, byte/half/word data-memory access with
// stall and timeout, and the MEM/WB pipeline register.
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inValid,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [1:0]  memSize,
  input  logic        memSigned,
  input  logic        branch,
  input  logic        regWrite,
  input  logic        memToReg,
  input  logic        zero,
  input  logic [31:0] addResult,
  input  logic [31:0] aluResult,
  input  logic [31:0] reg2,
  input  logic [4:0]  muxRegDstOut,
  output logic        pcSrc,
  output logic [31:0] branchTarget,
  output logic        stall,
  mem_access_stage_if.master dmem,
  output logic        addrError,
  output logic        busError,
  output logic        wbRegWrite,
  output logic        wbMemToReg,
  output logic [31:0] wbReadData,
  output logic [31:0] wbAluResult,
  output logic [4:0]  wbWriteReg
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  state_t      state, next_state;
  logic [7:0]  cnt;
  logic        memOp, misaligned;
  logic        req, we, wb_load, wb_ok, take_rdata;
  logic        addr_err_n, bus_err_n, cnt_clr, cnt_inc;
  logic [3:0]  be;
  logic [31:0] wdata, load_data;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign pcSrc        = inValid & branch & zero;
  assign branchTarget = addResult;
  assign memOp        = inValid & (memRead | memWrite);

  assign dmem.memReq   = req;
  assign dmem.memWe    = we;
  assign dmem.memAddr  = {aluResult[31:2], 2'b00};
  assign dmem.memBe    = be;
  assign dmem.memWdata = wdata;

  // Alignment check for the addressed access size.
  always_comb begin
    misaligned = 1'b0;
    case (memSize)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = memOp & aluResult[0];
      default: misaligned = memOp & (|aluResult[1:0]);
    endcase
  end

  // Byte enables and lane-replicated store data.
  always_comb begin
    be    = '0;
    wdata = '0;
    case (memSize)
      2'b00: begin
        be    = 4'b0001 << aluResult[1:0];
        wdata = {4{reg2[7:0]}};
      end
      2'b01: begin
        be    = aluResult[1] ? 4'b1100 : 4'b0011;
        wdata = {2{reg2[15:0]}};
      end
      default: begin
        be    = '1;
        wdata = reg2;
      end
    endcase
  end

  // Lane select and sign/zero extension of load data.
  always_comb begin
    byte_sel  = '0;
    load_data = '0;
    case (aluResult[1:0])
      2'b00: byte_sel = dmem.memRdata[7:0];
      2'b01: byte_sel = dmem.memRdata[15:8];
      2'b10: byte_sel = dmem.memRdata[23:16];
      2'b11: byte_sel = dmem.memRdata[31:24];
    endcase
    half_sel = aluResult[1] ? dmem.memRdata[31:16] : dmem.memRdata[15:0];
    case (memSize)
      2'b00:   load_data = {{24{memSigned & byte_sel[7]}}, byte_sel};
      2'b01:   load_data = {{16{memSigned & half_sel[15]}}, half_sel};
      default: load_data = dmem.memRdata;
    endcase
  end

  // Access FSM: next state, handshake, stall and MEM/WB load control.
  // Everything is held inactive while reset is asserted so an in-flight
  // access cannot leak a request or stall into the reset cycle.
  always_comb begin
    next_state = state;
    stall      = 1'b0;
    req        = 1'b0;
    we         = 1'b0;
    wb_load    = 1'b0;
    wb_ok      = 1'b0;
    take_rdata = 1'b0;
    addr_err_n = 1'b0;
    bus_err_n  = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (memOp && !misaligned) begin
            stall      = 1'b1;
            cnt_clr    = 1'b1;
            next_state = ACCESS;
          end else begin
            wb_load    = 1'b1;
            wb_ok      = !misaligned;
            addr_err_n = misaligned;
          end
        end
        ACCESS: begin
          req = 1'b1;
          we  = memWrite;
          if (dmem.memAck) begin
            wb_load    = 1'b1;
            wb_ok      = 1'b1;
            take_rdata = !memWrite;
            next_state = IDLE;
          end else if (cnt == LAST) begin
            wb_load    = 1'b1;
            bus_err_n  = 1'b1;
            next_state = IDLE;
          end else begin
            stall   = 1'b1;
            cnt_inc = 1'b1;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // State, timeout counter, error pulses and MEM/WB register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      addrError   <= 1'b0;
      busError    <= 1'b0;
      wbRegWrite  <= 1'b0;
      wbMemToReg  <= 1'b0;
      wbReadData  <= '0;
      wbAluResult <= '0;
      wbWriteReg  <= '0;
    end else begin
      state     <= next_state;
      addrError <= addr_err_n;
      busError  <= bus_err_n;
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 8'd1;
      if (wb_load) begin
        wbRegWrite  <= regWrite & inValid & wb_ok;
        wbMemToReg  <= memToReg;
        wbReadData  <= take_rdata ? load_data : '0;
        wbAluResult <= aluResult;
        wbWriteReg  <= muxRegDstOut;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage with a behavioural memory model.
module tb_mem_access_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        inValid, memRead, memWrite, memSigned, branch, regWrite, memToReg, zero;
  logic [1:0]  memSize;
  logic [31:0] addResult, aluResult, reg2;
  logic [4:0]  muxRegDstOut;
  logic        pcSrc, stall, addrError, busError;
  logic [31:0] branchTarget;
  logic        wbRegWrite, wbMemToReg;
  logic [31:0] wbReadData, wbAluResult;
  logic [4:0]  wbWriteReg;

  int total = 0;
  int bad   = 0;

  mem_access_stage_if bus ();

  mem_access_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .inValid(inValid), .memRead(memRead),
    .memWrite(memWrite), .memSize(memSize), .memSigned(memSigned),
    .branch(branch), .regWrite(regWrite), .memToReg(memToReg), .zero(zero),
    .addResult(addResult), .aluResult(aluResult), .reg2(reg2),
    .muxRegDstOut(muxRegDstOut), .pcSrc(pcSrc), .branchTarget(branchTarget),
    .stall(stall), .dmem(bus.master), .addrError(addrError), .busError(busError),
    .wbRegWrite(wbRegWrite), .wbMemToReg(wbMemToReg), .wbReadData(wbReadData),
    .wbAluResult(wbAluResult), .wbWriteReg(wbWriteReg)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit model_mis(input logic [1:0] sz, input logic [31:0] a);
    return (a % nbytes(sz)) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
    int n;
    n = nbytes(sz);
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] d);
    int n;
    n = nbytes(sz);
    if (n == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (n == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input bit sg,
                                             input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    int n;
    n = nbytes(sz);
    if (n == 4) return rd;
    v = (rd >> (8 * (a % 4))) & ((32'd1 << (8 * n)) - 32'd1);
    if (sg && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
    return v;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bubble();
    inValid = 0; memRead = 0; memWrite = 0; branch = 0; regWrite = 0;
    memToReg = 0; zero = 0;
  endtask

  // Non-memory instruction or bubble; entered and left at posedge+1.
  task automatic do_alu(input bit v, input bit rw, input bit m2r, input bit br,
                        input bit z, input logic [31:0] alu, input logic [31:0] tgt,
                        input logic [4:0] dst, input string nm);
    inValid = v; memRead = 0; memWrite = 0; regWrite = rw; memToReg = m2r;
    branch = br; zero = z; aluResult = alu; addResult = tgt; muxRegDstOut = dst;
    memSize = 2'($urandom_range(0, 3)); reg2 = $urandom;
    bus.memAck = 1'($urandom_range(0, 1)); bus.memRdata = $urandom;
    #1;
    total++; if (pcSrc !== (v & br & z)) begin bad++; $display("FAIL %s pcSrc got=%b exp=%b", nm, pcSrc, v & br & z); end
    total++; if (branchTarget !== tgt) begin bad++; $display("FAIL %s branchTarget got=%h exp=%h", nm, branchTarget, tgt); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL %s stall got=%b exp=0", nm, stall); end
    total++; if (bus.memReq !== 1'b0) begin bad++; $display("FAIL %s memReq got=%b exp=0", nm, bus.memReq); end
    tick();
    bus.memAck = 0;
    total++; if (wbRegWrite !== (v & rw)) begin bad++; $display("FAIL %s wbRegWrite got=%b exp=%b", nm, wbRegWrite, v & rw); end
    total++; if (wbAluResult !== alu) begin bad++; $display("FAIL %s wbAluResult got=%h exp=%h", nm, wbAluResult, alu); end
    total++; if (wbWriteReg !== dst) begin bad++; $display("FAIL %s wbWriteReg got=%h exp=%h", nm, wbWriteReg, dst); end
    total++; if (wbMemToReg !== m2r) begin bad++; $display("FAIL %s wbMemToReg got=%b exp=%b", nm, wbMemToReg, m2r); end
    total++; if (wbReadData !== 32'd0) begin bad++; $display("FAIL %s wbReadData got=%h exp=0", nm, wbReadData); end
  endtask

  // Memory instruction; ack arrives on ACCESS cycle index lat (lat >= TO: never).
  task automatic do_mem(input bit st, input bit both, input logic [1:0] sz, input bit sg,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                        input int lat, input bit rw, input bit m2r, input logic [4:0] dst,
                        input string nm);
    bit mis, tmo, done;
    int reqc, stallc, exp_req, exp_stall;
    logic [31:0] exp_rd;
    mis = model_mis(sz, a);
    tmo = !mis && lat >= TO;
    exp_req   = mis ? 0 : (tmo ? TO : lat + 1);
    exp_stall = exp_req;
    exp_rd    = (!mis && !tmo && !st) ? model_load(sz, sg, a, rd) : 32'd0;
    reqc = 0; stallc = 0; done = 0;
    inValid = 1; memWrite = st; memRead = st ? both : 1'b1; memSize = sz;
    memSigned = sg; aluResult = a; reg2 = wd; regWrite = rw; memToReg = m2r;
    muxRegDstOut = dst; branch = 0; zero = 0; bus.memAck = 0; bus.memRdata = $urandom;
    #1;
    for (int k = 0; k < 40 && !done; k++) begin
      if (bus.memReq === 1'b1) begin
        reqc++;
        total++; if (bus.memWe !== st) begin bad++; $display("FAIL %s memWe got=%b exp=%b", nm, bus.memWe, st); end
        total++; if (bus.memAddr !== (a & ~32'd3)) begin bad++; $display("FAIL %s memAddr got=%h exp=%h", nm, bus.memAddr, a & ~32'd3); end
        total++; if (bus.memBe !== model_be(sz, a)) begin bad++; $display("FAIL %s memBe got=%b exp=%b", nm, bus.memBe, model_be(sz, a)); end
        if (st) begin
          total++; if (bus.memWdata !== model_wdata(sz, wd)) begin bad++; $display("FAIL %s memWdata got=%h exp=%h", nm, bus.memWdata, model_wdata(sz, wd)); end
        end
        if (reqc - 1 == lat) begin bus.memAck = 1; bus.memRdata = rd; end
      end
      #1;
      if (stall === 1'b1) stallc++; else done = 1;
      tick();
      bus.memAck = 0; bus.memRdata = $urandom;
      if (!done) #1;
    end
    total++; if (!done) begin bad++; $display("FAIL %s stall_release got=stuck exp=released", nm); end
    total++; if (reqc != exp_req) begin bad++; $display("FAIL %s memReq_cycles got=%0d exp=%0d", nm, reqc, exp_req); end
    total++; if (stallc != exp_stall) begin bad++; $display("FAIL %s stall_cycles got=%0d exp=%0d", nm, stallc, exp_stall); end
    total++; if (addrError !== mis) begin bad++; $display("FAIL %s addrError got=%b exp=%b", nm, addrError, mis); end
    total++; if (busError !== tmo) begin bad++; $display("FAIL %s busError got=%b exp=%b", nm, busError, tmo); end
    total++; if (wbRegWrite !== (rw & !mis & !tmo)) begin bad++; $display("FAIL %s wbRegWrite got=%b exp=%b", nm, wbRegWrite, rw & !mis & !tmo); end
    total++; if (wbReadData !== exp_rd) begin bad++; $display("FAIL %s wbReadData got=%h exp=%h", nm, wbReadData, exp_rd); end
    total++; if (wbAluResult !== a) begin bad++; $display("FAIL %s wbAluResult got=%h exp=%h", nm, wbAluResult, a); end
    total++; if (wbWriteReg !== dst) begin bad++; $display("FAIL %s wbWriteReg got=%h exp=%h", nm, wbWriteReg, dst); end
    total++; if (wbMemToReg !== m2r) begin bad++; $display("FAIL %s wbMemToReg got=%b exp=%b", nm, wbMemToReg, m2r); end
    set_bubble();
    tick();
    total++; if ((addrError | busError) !== 1'b0) begin bad++; $display("FAIL %s error_pulse_width got=%b%b exp=00", nm, addrError, busError); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    total++; if (bus.memReq !== 1'b0 || bus.memWe !== 1'b0) begin bad++; $display("FAIL reset memReq/memWe got=%b%b exp=00", bus.memReq, bus.memWe); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset stall got=%b exp=0", stall); end
    total++; if ({addrError, busError, wbRegWrite, wbMemToReg} !== 4'b0) begin bad++; $display("FAIL reset flags got=%b exp=0000", {addrError, busError, wbRegWrite, wbMemToReg}); end
    total++; if ({wbReadData, wbAluResult, wbWriteReg} !== '0) begin bad++; $display("FAIL reset wbdata got=%h %h %h exp=0", wbReadData, wbAluResult, wbWriteReg); end
    reset = 0;
  endtask

  task automatic test_branch_alu();
    do_alu(1, 0, 0, 1, 1, 32'h0, 32'h40, 5'd0, "beq_taken");
    do_alu(1, 0, 0, 1, 0, 32'h5, 32'h80, 5'd0, "beq_not_taken");
    do_alu(0, 1, 0, 1, 1, 32'h6, 32'h44, 5'd3, "bubble_branch");
    do_alu(1, 1, 0, 0, 0, 32'd7, 32'h0, 5'd9, "add");
  endtask

  task automatic test_lb();
    do_mem(0, 0, 2'b00, 1, 32'h103, 32'h0, 32'h80AA_BBCC, 2, 1, 1, 5'd4, "lb_signed");
  endtask

  task automatic test_sh();
    do_mem(1, 0, 2'b01, 0, 32'h202, 32'h1234_ABCD, 32'h0, 0, 0, 0, 5'd0, "sh");
  endtask

  task automatic test_misaligned();
    do_mem(0, 0, 2'b10, 0, 32'h101, 32'h0, 32'hDEAD_BEEF, 0, 1, 1, 5'd6, "lw_misaligned");
    do_mem(1, 0, 2'b01, 0, 32'h303, 32'h55, 32'h0, 0, 0, 0, 5'd0, "sh_misaligned");
  endtask

  task automatic test_timeout();
    do_mem(0, 0, 2'b10, 0, 32'h400, 32'h0, 32'h1111_2222, 100, 1, 1, 5'd7, "lw_timeout");
    do_mem(0, 0, 2'b10, 0, 32'h404, 32'h0, 32'h3333_4444, TO - 1, 1, 1, 5'd8, "lw_last_cycle_ack");
  endtask

  task automatic test_random_mix();
    logic [31:0] a;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        do_alu(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
               1'($urandom), $urandom, $urandom, 5'($urandom), "rand_alu");
      end else begin
        a = $urandom;
        if ($urandom_range(0, 3) != 0) a = a & ~32'd3;
        do_mem(1'($urandom), 1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), a,
               $urandom, $urandom, $urandom_range(0, 5), 1'($urandom), 1'($urandom),
               5'($urandom), "rand_mem");
      end
    end
  endtask

  task automatic test_reset_mid_access();
    do_alu(1, 1, 1, 0, 0, 32'hCAFE_F00D, 32'h0, 5'd17, "pre_reset_add");
    inValid = 1; memRead = 1; memWrite = 0; memSize = 2'b10; aluResult = 32'h300;
    regWrite = 1; muxRegDstOut = 5'd2; bus.memAck = 0;
    tick(); tick();
    total++; if (bus.memReq !== 1'b1) begin bad++; $display("FAIL mid_reset in_access got=%b exp=1", bus.memReq); end
    reset = 1; set_bubble();
    tick();
    total++; if (bus.memReq !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL mid_reset req/stall got=%b%b exp=00", bus.memReq, stall); end
    total++; if ({wbRegWrite, wbMemToReg, wbReadData, wbAluResult, wbWriteReg} !== '0) begin bad++; $display("FAIL mid_reset wb got=%b %h %h exp=0", wbRegWrite, wbAluResult, wbWriteReg); end
    reset = 0; bus.memAck = 1; bus.memRdata = 32'hFFFF_FFFF;
    #1;
    total++; if (bus.memReq !== 1'b0) begin bad++; $display("FAIL late_ack memReq got=%b exp=0", bus.memReq); end
    tick();
    bus.memAck = 0;
    total++; if (wbRegWrite !== 1'b0 || wbReadData !== 32'd0) begin bad++; $display("FAIL late_ack wb got=%b %h exp=0 0", wbRegWrite, wbReadData); end
  endtask

  initial begin
    reset = 1; set_bubble(); memSize = 0; memSigned = 0; addResult = 0;
    aluResult = 0; reg2 = 0; muxRegDstOut = 0; bus.memAck = 0; bus.memRdata = 0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_branch_alu();
    test_lb();
    test_sh();
    test_misaligned();
    test_timeout();
    test_random_mix();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
